alpaca_fft_framer: RTL

// - Downstream neighbour of alpaca_phasecomp; feeds the FFT input port.
// - Phasecomp emits a continuous rotated sample stream. This block aligns it
//   to FFT frame boundaries using the start-of-frame marker s_axis.tuser[0].
// - It regenerates tlast/tuser per frame of FFT_LEN samples.
// - It absorbs FFT backpressure with a registered 2-entry skid buffer and

---
 rtl/alpaca_fft_framer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alpaca_fft_framer.sv
// Aligns a continuous sample stream to FFT frame boundaries, regenerates tuser/tlast and
// absorbs backpressure with a 2-entry skid buffer. Optional counters: ALPACA_FRAMER_STATS_EN.
module alpaca_fft_framer #(
  parameter int unsigned FFT_LEN      = 32,
  parameter int unsigned SAMP_PER_CLK = 2,
  parameter int unsigned SAMPLE_W     = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [SAMP_PER_CLK*SAMPLE_W-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic                             s_axis_tuser,
  output logic [SAMP_PER_CLK*SAMPLE_W-1:0] m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tuser,
  output logic                             sync_err,
  output logic                             locked
`ifdef ALPACA_FRAMER_STATS_EN
  ,
  output logic [31:0]                      frame_cnt,
  output logic [15:0]                      drop_cnt
`endif
);

  localparam int unsigned DATA_W = SAMP_PER_CLK * SAMPLE_W;
  localparam int unsigned BEATS  = FFT_LEN / SAMP_PER_CLK;
  localparam int unsigned CNT_W  = $clog2(BEATS);

  typedef enum logic {SEEK = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;
  logic               cnt_zero;
  logic               cnt_last;
  logic               resync;
  logic               miss;
  logic               fwd;
  logic               fwd_last;

  logic [DATA_W-1:0]  sk_data;
  logic               sk_user;
  logic               sk_last;
  logic               sk_valid;
  logic               pop;
  logic               out_v_n;
  logic               sk_v_n;
  logic               out_load_sk;
  logic               out_load_in;
  logic               sk_load;
  logic               ready_n;

  // Input tlast carries no information here; frame boundaries come from the counter.
  logic               unused_tlast;
  assign unused_tlast = s_axis_tlast;

  // Frame decode of the beat being accepted this cycle.
  always_comb begin
    accept   = s_axis_tvalid & s_axis_tready;
    cnt_zero = (beat_cnt == '0);
    cnt_last = (beat_cnt == CNT_W'(BEATS - 1));
    cnt_inc  = cnt_last ? '0 : beat_cnt + CNT_W'(1);
    resync   = accept & (state == RUN) & s_axis_tuser & ~cnt_zero;
    miss     = accept & (state == RUN) & ~s_axis_tuser & cnt_zero;
    // A forwarded beat is a frame start exactly when its input tuser is set.
    fwd      = accept & (s_axis_tuser | ((state == RUN) & ~cnt_zero));
    fwd_last = ~s_axis_tuser & cnt_last;
  end

  // Lock FSM and beat counter; advance only on the input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEEK;
      beat_cnt <= '0;
      sync_err <= 1'b0;
      locked   <= 1'b0;
    end else begin
      sync_err <= resync | miss;
      if (accept) begin
        case (state)
          SEEK: begin
            if (s_axis_tuser) begin
              state    <= RUN;
              beat_cnt <= CNT_W'(1);
              locked   <= 1'b1;
            end
          end
          RUN: begin
            if (miss) begin
              state    <= SEEK;
              beat_cnt <= '0;
              locked   <= 1'b0;
            end else if (s_axis_tuser) begin
              beat_cnt <= CNT_W'(1);
            end else begin
              beat_cnt <= cnt_inc;
            end
          end
          default: begin
            state    <= SEEK;
            beat_cnt <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Skid buffer: the output register is the head, sk_* the second entry.
  always_comb begin
    pop         = m_axis_tvalid & m_axis_tready;
    out_v_n     = m_axis_tvalid;
    sk_v_n      = sk_valid;
    out_load_sk = 1'b0;
    out_load_in = 1'b0;
    sk_load     = 1'b0;
    if (!m_axis_tvalid || pop) begin
      if (sk_valid) begin
        out_load_sk = 1'b1;
        out_v_n     = 1'b1;
        sk_load     = fwd;
        sk_v_n      = fwd;
      end else begin
        out_load_in = fwd;
        out_v_n     = fwd;
      end
    end else if (fwd) begin
      sk_load = 1'b1;
      sk_v_n  = 1'b1;
    end
    ready_n = ~(out_v_n & sk_v_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      sk_valid      <= 1'b0;
      sk_data       <= '0;
      sk_user       <= 1'b0;
      sk_last       <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      m_axis_tvalid <= out_v_n;
      sk_valid      <= sk_v_n;
      s_axis_tready <= ready_n;
      if (out_load_sk) begin
        m_axis_tdata <= sk_data;
        m_axis_tuser <= sk_user;
        m_axis_tlast <= sk_last;
      end else if (out_load_in) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tuser <= s_axis_tuser;
        m_axis_tlast <= fwd_last;
      end
      if (sk_load) begin
        sk_data <= s_axis_tdata;
        sk_user <= s_axis_tuser;
        sk_last <= fwd_last;
      end
    end
  end

`ifdef ALPACA_FRAMER_STATS_EN
  // Completed-frame counter wraps; drop counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (pop && m_axis_tlast) frame_cnt <= frame_cnt + 32'd1;
      if (accept && !fwd && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
